axi_rd_arbiter: RTL

- Shares the single AXI read channel (AR/R) between the instruction-side requester and the data-side requester (d-cache + uncached path).
- Grants one requester at a time and holds the grant through the full burst.
- m_rdata and m_rlast fan out directly to both requesters; this block only steers valid/ready.
- Applies round-robin fairness and blocks data reads while the data write path is busy (read-after-write ordering).

---
 rtl/axi_arb_pkg.sv | 27 ++
 rtl/axi_rd_arbiter_if.sv | 25 ++
 rtl/rr_pick2.sv | 37 +++
 rtl/axi_rd_arbiter.sv | 130 +++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI read-channel arbiter.
package axi_arb_pkg;

  localparam int unsigned IdW = 4;

  // Arbiter FSM: idle, then address and data phases for each side.
  typedef enum logic [2:0] {
    StIdle,
    StIAr,
    StIR,
    StDAr,
    StDR
  } arb_state_e;

  // Encoding of the winner reported by the picker and kept as last_grant.
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  localparam logic [IdW-1:0] DEF_ID_I = 4'd0;
  localparam logic [IdW-1:0] DEF_ID_D = 4'd1;

  // True while the shared AR channel is being driven.
  function automatic logic is_ar_state(arb_state_e s);
    return (s == StIAr) || (s == StDAr);
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// Shared AXI read channel (AR + R handshake) between arbiter and slave.
interface axi_rd_arbiter_if;
  import axi_arb_pkg::*;

  logic [31:0]    araddr;
  logic [7:0]     arlen;
  logic [2:0]     arsize;
  logic [IdW-1:0] arid;
  logic           arvalid;
  logic           arready;
  logic           rvalid;
  logic           rlast;
  logic           rready;

  modport master (
    output araddr, arlen, arsize, arid, arvalid, rready,
    input  arready, rvalid, rlast
  );

  modport slave (
    input  araddr, arlen, arsize, arid, arvalid, rready,
    output arready, rvalid, rlast
  );

endinterface

// File: rtl/rr_pick2.sv
// Two-way picker: round-robin on collisions when FAIR, else data side wins.
module rr_pick2
  import axi_arb_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic req_d,
  input  logic take,     // commit the current pick as last_grant
  output logic pick,     // GRANT_I or GRANT_D
  output logic req_any
);

  logic last_q;

  assign req_any = req_i | req_d;

  // Winner selection; a lone requester always wins.
  always_comb begin
    pick = GRANT_I;
    if (req_d && (!req_i || !FAIR || (last_q == GRANT_I))) begin
      pick = GRANT_D;
    end
  end

  // Remember who was granted last so the other side wins the next collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= GRANT_I;
    end else if (take && req_any) begin
      last_q <= pick;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Arbitrates the single AXI read channel between instruction and data sides.
// The grant is held for the whole burst; only valid/ready are steered.
module axi_rd_arbiter
  import axi_arb_pkg::*;
#(
  parameter bit             FAIR = 1'b1,
  parameter logic [IdW-1:0] ID_I = DEF_ID_I,
  parameter logic [IdW-1:0] ID_D = DEF_ID_D
) (
  input  logic        clk,
  input  logic        rst,
  // Instruction-side requester
  input  logic [31:0] i_araddr,
  input  logic [7:0]  i_arlen,
  input  logic [2:0]  i_arsize,
  input  logic        i_arvalid,
  output logic        i_arready,
  output logic        i_rvalid,
  input  logic        i_rready,
  // Data-side requester
  input  logic [31:0] d_araddr,
  input  logic [7:0]  d_arlen,
  input  logic [2:0]  d_arsize,
  input  logic        d_arvalid,
  output logic        d_arready,
  output logic        d_rvalid,
  input  logic        d_rready,
  input  logic        wr_busy,
  // Shared read channel towards the slave
  axi_rd_arbiter_if.master bus
);

  arb_state_e     state_q, state_d;
  logic [31:0]    araddr_q, araddr_d;
  logic [7:0]     arlen_q, arlen_d;
  logic [2:0]     arsize_q, arsize_d;
  logic [IdW-1:0] arid_q, arid_d;

  logic req_d_elig;
  logic pick;
  logic req_any;
  logic in_idle;

  // Data reads wait for outstanding writes, but only at grant time.
  assign req_d_elig = d_arvalid & ~wr_busy;
  assign in_idle    = (state_q == StIdle);

  rr_pick2 #(
    .FAIR (FAIR)
  ) u_pick (
    .clk     (clk),
    .rst     (rst),
    .req_i   (i_arvalid),
    .req_d   (req_d_elig),
    .take    (in_idle),
    .pick    (pick),
    .req_any (req_any)
  );

  // Next state and AR payload capture.
  always_comb begin
    state_d  = state_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    arsize_d = arsize_q;
    arid_d   = arid_q;
    unique case (state_q)
      StIdle: begin
        if (req_any) begin
          if (pick == GRANT_D) begin
            state_d  = StDAr;
            araddr_d = d_araddr;
            arlen_d  = d_arlen;
            arsize_d = d_arsize;
            arid_d   = ID_D;
          end else begin
            state_d  = StIAr;
            araddr_d = i_araddr;
            arlen_d  = i_arlen;
            arsize_d = i_arsize;
            arid_d   = ID_I;
          end
        end
      end
      StIAr: if (bus.arready) state_d = StIR;
      StIR:  if (bus.rvalid && i_rready && bus.rlast) state_d = StIdle;
      StDAr: if (bus.arready) state_d = StDR;
      StDR:  if (bus.rvalid && d_rready && bus.rlast) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and AR payload registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      araddr_q <= '0;
      arlen_q  <= '0;
      arsize_q <= '0;
      arid_q   <= '0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      arsize_q <= arsize_d;
      arid_q   <= arid_d;
    end
  end

  assign bus.araddr = araddr_q;
  assign bus.arlen  = arlen_q;
  assign bus.arsize = arsize_q;
  assign bus.arid   = arid_q;

  // Handshake steering: only the granted side sees the channel.
  always_comb begin
    bus.arvalid = is_ar_state(state_q);
    i_arready   = (state_q == StIAr) && bus.arready;
    d_arready   = (state_q == StDAr) && bus.arready;
    i_rvalid    = (state_q == StIR) && bus.rvalid;
    d_rvalid    = (state_q == StDR) && bus.rvalid;
    bus.rready  = 1'b0;
    if (state_q == StIR) begin
      bus.rready = i_rready;
    end else if (state_q == StDR) begin
      bus.rready = d_rready;
    end
  end

endmodule
